// File: rtl/fast_ica_pkg.sv
// Shared types and helpers for the FastICA one-unit sequencer.
// Optional feature macro: FICA_CONV_CHECK_EN (tolerance-based early exit).
package fast_ica_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ITER,
        WAIT,
        CHECK,
        COMMIT,
        EXTRACT,
        DONE
    } fica_state_e;

    // Default Q-format: Q2.30, so ONE is 1 << 30.
    localparam int      FICA_FRAC_DEFAULT = 30;
    localparam longint  FICA_ONE_DEFAULT  = longint'(1) << FICA_FRAC_DEFAULT;

    // Index width for n items; never narrower than one bit.
    function automatic int fica_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the value n itself.
    function automatic int fica_cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/fica_conv_check.sv
// Convergence detector: registers (ONE - |dot|) <= TOL when sample is high.
// |dot| saturates the most-negative input to the largest positive value and
// all arithmetic is carried one bit wider than the input.
// Only instantiated when FICA_CONV_CHECK_EN is defined.
module fica_conv_check import fast_ica_pkg::*; #(
    parameter int DW   = 32,
    parameter int FRAC = 30,
    parameter int TOL  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample,
    input  logic signed [DW-1:0] dot,
    output logic                 conv
);

    localparam int XW = DW + 1;
    localparam logic signed [XW-1:0] ONE_X   = XW'(1) << FRAC;
    localparam logic signed [XW-1:0] TOL_X   = XW'(TOL);
    localparam logic signed [XW-1:0] MAX_POS = {2'b00, {(DW-1){1'b1}}};

    logic signed [XW-1:0] dot_ext;
    logic signed [XW-1:0] abs_val;
    logic signed [XW-1:0] diff;
    logic                 is_min;

    // Saturating absolute value and distance from ONE.
    always_comb begin
        dot_ext = {dot[DW-1], dot};
        is_min  = (dot == {1'b1, {(DW-1){1'b0}}});
        abs_val = dot_ext;
        if (is_min) begin
            abs_val = MAX_POS;
        end else if (dot[DW-1]) begin
            abs_val = -dot_ext;
        end
        diff = ONE_X - abs_val;
    end

    // Capture the convergence decision alongside the accepted dot product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv <= 1'b0;
        end else if (sample) begin
            conv <= (diff <= TOL_X);
        end
    end

endmodule

// File: rtl/fast_ica_sequencer.sv
// FastICA sequencer: per component, load w, iterate updates until converged
// or MAX_ITER, commit w into the unmixing column, then launch extraction.
// Build option FICA_CONV_CHECK_EN enables tolerance-based early exit; without
// it each component runs exactly MAX_ITER updates and is flagged complete.
module fast_ica_sequencer import fast_ica_pkg::*; #(
    parameter int SIZE_C   = 3,
    parameter int MAX_ITER = 64,
    parameter int DW       = 32,
    parameter int FRAC     = FICA_FRAC_DEFAULT,
    parameter int TOL      = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    output logic                              busy,
    output logic                              done,
    output logic [fica_idx_w(SIZE_C)-1:0]     comp_idx,
    output logic [fica_cnt_w(MAX_ITER)-1:0]   iter_cnt,
    output logic                              w_init_load,
    output logic                              dp_start,
    input  logic                              dp_done,
    input  logic signed [DW-1:0]              dp_dot,
    output logic                              w_commit,
    output logic                              ext_start,
    input  logic                              ext_done,
    output logic [SIZE_C-1:0]                 conv_flags
);

    localparam int CW = fica_idx_w(SIZE_C);
    localparam int IW = fica_cnt_w(MAX_ITER);
    localparam logic [CW-1:0] LAST_COMP = CW'(SIZE_C - 1);
    localparam logic [IW-1:0] ITER_MAX  = IW'(MAX_ITER);

    fica_state_e state_reg;
    logic        conv_bit;

`ifdef FICA_CONV_CHECK_EN
    fica_conv_check #(
        .DW   (DW),
        .FRAC (FRAC),
        .TOL  (TOL)
    ) u_conv_check (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample ((state_reg == WAIT) && dp_done),
        .dot    (dp_dot),
        .conv   (conv_bit)
    );
`else
    // Without the tolerance test a component is finished only by the
    // iteration limit; the dot product is deliberately left unused.
    localparam int UNUSED_CFG_SUM = DW + FRAC + TOL;
    logic unused_dot;
    assign unused_dot = ^dp_dot;
    assign conv_bit   = (iter_cnt == ITER_MAX);
`endif

    // Main sequencing FSM; every output is a register set on entry to the
    // state that owns it, so pulses are exactly one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            comp_idx    <= '0;
            iter_cnt    <= '0;
            w_init_load <= 1'b0;
            dp_start    <= 1'b0;
            w_commit    <= 1'b0;
            ext_start   <= 1'b0;
            conv_flags  <= '0;
        end else begin
            w_init_load <= 1'b0;
            dp_start    <= 1'b0;
            w_commit    <= 1'b0;
            ext_start   <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                // Partial conv_flags are intentionally kept for inspection.
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            state_reg   <= INIT;
                            busy        <= 1'b1;
                            comp_idx    <= '0;
                            iter_cnt    <= '0;
                            conv_flags  <= '0;
                            w_init_load <= 1'b1;
                        end
                    end
                    INIT: begin
                        iter_cnt  <= '0;
                        dp_start  <= 1'b1;
                        state_reg <= ITER;
                    end
                    ITER: begin
                        state_reg <= WAIT;
                    end
                    WAIT: begin
                        if (dp_done) begin
                            iter_cnt  <= iter_cnt + 1'b1;
                            state_reg <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (conv_bit) begin
                            conv_flags[comp_idx] <= 1'b1;
                            w_commit             <= 1'b1;
                            state_reg            <= COMMIT;
                        end else if (iter_cnt == ITER_MAX) begin
                            w_commit  <= 1'b1;
                            state_reg <= COMMIT;
                        end else begin
                            dp_start  <= 1'b1;
                            state_reg <= ITER;
                        end
                    end
                    COMMIT: begin
                        if (comp_idx == LAST_COMP) begin
                            ext_start <= 1'b1;
                            state_reg <= EXTRACT;
                        end else begin
                            comp_idx    <= comp_idx + 1'b1;
                            iter_cnt    <= '0;
                            w_init_load <= 1'b1;
                            state_reg   <= INIT;
                        end
                    end
                    EXTRACT: begin
                        if (ext_done) begin
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                    DONE: begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fast_ica_sequencer.sv
// Directed testbench for fast_ica_sequencer (SIZE_C=3, MAX_ITER=4, Q2.30).
// Expected values follow the FICA_CONV_CHECK_EN build setting.
module tb_fast_ica_sequencer;

    localparam int SIZE_C   = 3;
    localparam int MAX_ITER = 4;
    localparam int DW       = 32;
    localparam int FRAC     = 30;
    localparam int TOL      = 1024;

    localparam logic signed [31:0] ONE      = 32'sh4000_0000;
    localparam logic signed [31:0] NEAR_NEG = -32'sd1073741312; // -(ONE-512)

`ifdef FICA_CONV_CHECK_EN
    localparam bit CONV_EN = 1'b1;
`else
    localparam bit CONV_EN = 1'b0;
`endif

    // Hand-derived expectations for each dot-product pattern.
    localparam int       EXP_START_ONE  = CONV_EN ? 3 : 12;
    localparam int       EXP_ITER_ONE   = CONV_EN ? 1 : 4;
    localparam int       EXP_START_ZERO = 12;
    localparam logic [2:0] EXP_FLAGS_ZERO = CONV_EN ? 3'b000 : 3'b111;
    localparam int       EXP_START_NEG  = CONV_EN ? 6 : 12;
    localparam int       EXP_ITER_NEG   = CONV_EN ? 2 : 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic [1:0]         comp_idx;
    logic [2:0]         iter_cnt;
    logic               w_init_load;
    logic               dp_start;
    logic               dp_done;
    logic signed [31:0] dp_dot;
    logic               w_commit;
    logic               ext_start;
    logic               ext_done;
    logic [2:0]         conv_flags;

    int n_checks = 0;
    int n_fail   = 0;
    int n_init, n_start, n_commit, n_ext, n_done;
    int commit_iter0, first_comp;

    fast_ica_sequencer #(
        .SIZE_C   (SIZE_C),
        .MAX_ITER (MAX_ITER),
        .DW       (DW),
        .FRAC     (FRAC),
        .TOL      (TOL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .comp_idx    (comp_idx),
        .iter_cnt    (iter_cnt),
        .w_init_load (w_init_load),
        .dp_start    (dp_start),
        .dp_done     (dp_done),
        .dp_dot      (dp_dot),
        .w_commit    (w_commit),
        .ext_start   (ext_start),
        .ext_done    (ext_done),
        .conv_flags  (conv_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full (or aborted) pass with a datapath model.
    // dot_mode: 0 = ONE always, 1 = zero always, 2 = -(ONE-512) on 2nd update.
    // stop_mode: 0 = run to done, 1 = abort on EXTRACT, 2 = abort at first COMMIT.
    task automatic run_pass(input int dot_mode, input bit spurious,
                            input bit start_busy, input int stop_mode);
        int k, upd, ext_go;
        bit abort_sent, ok;
        n_init = 0; n_start = 0; n_commit = 0; n_ext = 0; n_done = 0;
        commit_iter0 = -1; first_comp = -1;
        k = -1; upd = 0; ext_go = 0; abort_sent = 1'b0; ok = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = start_busy && (c == 6);
            if (abort_sent) begin
                abort = 1'b0;
                ok = 1'b1;
                break;
            end
            ext_done = (ext_go != 0);
            ext_go = 0;
            if (w_init_load) begin
                n_init++;
                upd = 0;
                if (first_comp < 0) first_comp = comp_idx;
            end
            if (dp_start) begin
                n_start++;
                upd++;
                k = 0;
            end
            if (w_commit) begin
                if (n_commit == 0) commit_iter0 = iter_cnt;
                n_commit++;
                if (stop_mode == 2) begin abort = 1'b1; abort_sent = 1'b1; end
            end
            if (ext_start) begin
                n_ext++;
                if (stop_mode == 1) begin abort = 1'b1; abort_sent = 1'b1; end
                else ext_go = 1;
            end
            if (done) begin
                n_done++;
                ok = 1'b1;
            end
            // Spurious pattern pulses dp_done in ITER and CHECK as well.
            if (k < 0) begin
                dp_done = 1'b0;
            end else if (spurious) begin
                dp_done = (k == 0) || (k == 2) || (k == 3);
                k = (k >= 3) ? -1 : k + 1;
            end else begin
                dp_done = (k == 1);
                k = (k >= 1) ? -1 : k + 1;
            end
            case (dot_mode)
                0:       dp_dot = ONE;
                1:       dp_dot = 32'sd0;
                default: dp_dot = (upd == 2) ? NEAR_NEG : 32'sd0;
            endcase
            if (done) break;
        end
        start = 1'b0; dp_done = 1'b0; ext_done = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL pass_timeout: pass did not finish, done=%0d busy=%0d", done, busy);
        end
        $display("pass dot_mode=%0d spur=%0d stop=%0d: init=%0d start=%0d commit=%0d ext=%0d done=%0d flags=%b",
                 dot_mode, spurious, stop_mode, n_init, n_start, n_commit, n_ext, n_done, conv_flags);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        dp_done = 1'b0; ext_done = 1'b0; dp_dot = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, w_init_load, dp_start, w_commit, ext_start} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {busy, done, w_init_load, dp_start, w_commit, ext_start});
        end
        n_checks++;
        if ({comp_idx, iter_cnt, conv_flags} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_counters: got comp=%0d iter=%0d flags=%b, want 0/0/000",
                     comp_idx, iter_cnt, conv_flags);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_full_run();
        run_pass(0, 1'b0, 1'b0, 0);
        n_checks++;
        if (n_init !== 3 || n_commit !== 3 || n_ext !== 1 || n_done !== 1) begin
            n_fail++;
            $display("FAIL full_pulses: got init=%0d commit=%0d ext=%0d done=%0d, want 3/3/1/1",
                     n_init, n_commit, n_ext, n_done);
        end
        n_checks++;
        if (n_start !== EXP_START_ONE) begin
            n_fail++;
            $display("FAIL full_dp_start: got %0d, want %0d", n_start, EXP_START_ONE);
        end
        n_checks++;
        if (commit_iter0 !== EXP_ITER_ONE || first_comp !== 0) begin
            n_fail++;
            $display("FAIL full_iter: got iter=%0d comp=%0d, want %0d/0",
                     commit_iter0, first_comp, EXP_ITER_ONE);
        end
        n_checks++;
        if (conv_flags !== 3'b111) begin
            n_fail++;
            $display("FAIL full_flags: got %b, want 111", conv_flags);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after_done: got done=%0d busy=%0d, want 0/0", done, busy);
        end
    endtask

    task automatic test_no_conv();
        run_pass(1, 1'b0, 1'b0, 0);
        n_checks++;
        if (n_start !== EXP_START_ZERO || n_done !== 1) begin
            n_fail++;
            $display("FAIL noconv_counts: got start=%0d done=%0d, want %0d/1",
                     n_start, n_done, EXP_START_ZERO);
        end
        n_checks++;
        if (conv_flags !== EXP_FLAGS_ZERO) begin
            n_fail++;
            $display("FAIL noconv_flags: got %b, want %b", conv_flags, EXP_FLAGS_ZERO);
        end
        @(negedge clk);
    endtask

    task automatic test_negative_dot();
        run_pass(2, 1'b0, 1'b0, 0);
        n_checks++;
        if (n_start !== EXP_START_NEG || commit_iter0 !== EXP_ITER_NEG) begin
            n_fail++;
            $display("FAIL neg_counts: got start=%0d iter=%0d, want %0d/%0d",
                     n_start, commit_iter0, EXP_START_NEG, EXP_ITER_NEG);
        end
        n_checks++;
        if (conv_flags !== 3'b111) begin
            n_fail++;
            $display("FAIL neg_flags: got %b, want 111", conv_flags);
        end
        @(negedge clk);
    endtask

    task automatic test_spurious_and_start_busy();
        run_pass(0, 1'b1, 1'b1, 0);
        n_checks++;
        if (n_init !== 3 || n_done !== 1 || n_start !== EXP_START_ONE) begin
            n_fail++;
            $display("FAIL spurious_counts: got init=%0d done=%0d start=%0d, want 3/1/%0d",
                     n_init, n_done, n_start, EXP_START_ONE);
        end
        n_checks++;
        if (commit_iter0 !== EXP_ITER_ONE) begin
            n_fail++;
            $display("FAIL spurious_iter: got %0d, want %0d", commit_iter0, EXP_ITER_ONE);
        end
        @(negedge clk);
    endtask

    task automatic test_abort_extract();
        int seen_done;
        run_pass(0, 1'b0, 1'b0, 1);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ext_start !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ext_idle: got busy=%0d done=%0d ext_start=%0d, want 0/0/0",
                     busy, done, ext_start);
        end
        n_checks++;
        if (conv_flags !== 3'b111 || n_ext !== 1 || n_start !== EXP_START_ONE) begin
            n_fail++;
            $display("FAIL abort_ext_state: got flags=%b ext=%0d start=%0d, want 111/1/%0d",
                     conv_flags, n_ext, n_start, EXP_START_ONE);
        end
        seen_done = 0;
        ext_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ext_done = 1'b0;
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL abort_ext_no_done: got %0d active cycles, want 0", seen_done);
        end
    endtask

    task automatic test_abort_partial();
        run_pass(0, 1'b0, 1'b0, 2);
        n_checks++;
        if (busy !== 1'b0 || w_commit !== 1'b0 || w_init_load !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_commit_idle: got busy=%0d w_commit=%0d w_init_load=%0d, want 0/0/0",
                     busy, w_commit, w_init_load);
        end
        n_checks++;
        if (conv_flags !== 3'b001 || n_commit !== 1) begin
            n_fail++;
            $display("FAIL abort_commit_flags: got flags=%b commits=%0d, want 001/1",
                     conv_flags, n_commit);
        end
        @(negedge clk);
    endtask

    task automatic test_start_abort_idle();
        int active;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        active = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy || w_init_load) active++;
            @(negedge clk);
        end
        n_checks++;
        if (active !== 0) begin
            n_fail++;
            $display("FAIL start_abort_idle: got %0d active cycles, want 0", active);
        end
        $display("start+abort in idle: active=%0d", active);
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        seen = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (dp_start) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_wait_reach: got no dp_start, want one within 20 cycles");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, w_init_load, dp_start, w_commit, ext_start, comp_idx, iter_cnt, conv_flags} !== 14'b0) begin
            n_fail++;
            $display("FAIL rst_wait_async: got %b, want all zero",
                     {busy, done, w_init_load, dp_start, w_commit, ext_start, comp_idx, iter_cnt, conv_flags});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pass(0, 1'b0, 1'b0, 0);
        n_checks++;
        if (n_init !== 3 || first_comp !== 0 || n_done !== 1 || conv_flags !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_wait_rerun: got init=%0d comp=%0d done=%0d flags=%b, want 3/0/1/111",
                     n_init, first_comp, n_done, conv_flags);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_no_conv();
        test_negative_dot();
        test_spurious_and_start_busy();
        test_abort_extract();
        test_abort_partial();
        test_start_abort_idle();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
